// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 brute-force key search.
// Phase watchdog support is selected with RC4_PHASE_WATCHDOG_EN.
package rc4_pkg;

    localparam int unsigned RC4_KEY_WIDTH = 24;
    localparam int unsigned RC4_MSG_LEN   = 32;

    // Plaintext character class accepted by the message checker.
    localparam logic [7:0] RC4_CHAR_LOWER_A = 8'h61;
    localparam logic [7:0] RC4_CHAR_LOWER_Z = 8'h7A;
    localparam logic [7:0] RC4_CHAR_SPACE   = 8'h20;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_GO,
        ST_INIT_WAIT,
        ST_SHUF_GO,
        ST_SHUF_WAIT,
        ST_DEC_GO,
        ST_DEC_WAIT,
        ST_ABORT,
        ST_NEXT_KEY,
        ST_FOUND,
        ST_EXHAUSTED,
        ST_TIMEOUT
    } rc4_state_e;

    function automatic logic is_go_state(input rc4_state_e s);
        return (s == ST_INIT_GO) || (s == ST_SHUF_GO) || (s == ST_DEC_GO);
    endfunction

    function automatic logic is_wait_state(input rc4_state_e s);
        return (s == ST_INIT_WAIT) || (s == ST_SHUF_WAIT) || (s == ST_DEC_WAIT);
    endfunction

    function automatic logic is_rest_state(input rc4_state_e s);
        return (s == ST_IDLE) || (s == ST_FOUND) || (s == ST_EXHAUSTED) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/rc4_phase_watchdog.sv
// Per-phase cycle counter; expired_c flags the last allowed wait cycle.
// Only instantiated when RC4_PHASE_WATCHDOG_EN is defined.
module rc4_phase_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c
);

    localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_c = enable_i && (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Sequencer stepping a candidate key through init, shuffle and decrypt phases.
// Optional per-phase watchdog enabled by defining RC4_PHASE_WATCHDOG_EN.
module rc4_key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int unsigned          KEY_WIDTH      = RC4_KEY_WIDTH,
    parameter logic [KEY_WIDTH-1:0] KEY_START      = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_END        = KEY_WIDTH'(24'h3F_FFFF),
    parameter int unsigned          TIMEOUT_CYCLES = 65536
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 init_finish,
    input  logic                 shuffle_finish,
    input  logic                 decrypt_finish,
    input  logic                 key_is_wrong,
    output logic                 init_start,
    output logic                 shuffle_start,
    output logic                 decrypt_start,
    output logic                 phase_abort,
    output logic                 check_restart,
    output logic [KEY_WIDTH-1:0] secret_key,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic                 timeout_err
);

    rc4_state_e           state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 wd_expired;

    logic init_start_q, init_start_d;
    logic shuf_start_q, shuf_start_d;
    logic dec_start_q, dec_start_d;
    logic abort_q, abort_d;
    logic busy_q, busy_d;
    logic found_q, found_d;
    logic exhausted_q, exhausted_d;

`ifdef RC4_PHASE_WATCHDOG_EN
    logic timeout_q, timeout_d;

    rc4_phase_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (is_go_state(state_q)),
        .enable_i  (is_wait_state(state_q)),
        .expired_c (wd_expired)
    );

    assign timeout_d   = (state_d == ST_TIMEOUT);
    assign timeout_err = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign wd_expired            = 1'b0;
    assign timeout_err           = 1'b0;
`endif

    // Next state and key; phase events take priority over watchdog expiry.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        case (state_q)
            ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_TIMEOUT: begin
                if (start) begin
                    state_d = ST_INIT_GO;
                    key_d   = KEY_START;
                end
            end
            ST_INIT_GO: state_d = ST_INIT_WAIT;
            ST_INIT_WAIT: begin
                if (init_finish)     state_d = ST_SHUF_GO;
                else if (wd_expired) state_d = ST_TIMEOUT;
            end
            ST_SHUF_GO: state_d = ST_SHUF_WAIT;
            ST_SHUF_WAIT: begin
                if (shuffle_finish)  state_d = ST_DEC_GO;
                else if (wd_expired) state_d = ST_TIMEOUT;
            end
            ST_DEC_GO: state_d = ST_DEC_WAIT;
            ST_DEC_WAIT: begin
                if (key_is_wrong)        state_d = ST_ABORT;
                else if (decrypt_finish) state_d = ST_FOUND;
                else if (wd_expired)     state_d = ST_TIMEOUT;
            end
            ST_ABORT: state_d = ST_NEXT_KEY;
            ST_NEXT_KEY: begin
                // Compare before increment so an all-ones KEY_END never wraps.
                if (key_q == KEY_END) begin
                    state_d = ST_EXHAUSTED;
                end else begin
                    state_d = ST_INIT_GO;
                    key_d   = key_q + KEY_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they register alongside it.
    always_comb begin
        init_start_d = (state_d == ST_INIT_GO);
        shuf_start_d = (state_d == ST_SHUF_GO);
        dec_start_d  = (state_d == ST_DEC_GO);
        abort_d      = (state_d == ST_ABORT) ||
                       ((state_d == ST_TIMEOUT) && (state_q != ST_TIMEOUT));
        busy_d       = !is_rest_state(state_d);
        found_d      = (state_d == ST_FOUND);
        exhausted_d  = (state_d == ST_EXHAUSTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            key_q        <= KEY_START;
            init_start_q <= 1'b0;
            shuf_start_q <= 1'b0;
            dec_start_q  <= 1'b0;
            abort_q      <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            init_start_q <= init_start_d;
            shuf_start_q <= shuf_start_d;
            dec_start_q  <= dec_start_d;
            abort_q      <= abort_d;
            busy_q       <= busy_d;
            found_q      <= found_d;
            exhausted_q  <= exhausted_d;
        end
    end

    assign init_start    = init_start_q;
    assign shuffle_start = shuf_start_q;
    assign decrypt_start = dec_start_q;
    assign phase_abort   = abort_q;
    assign check_restart = abort_q;
    assign secret_key    = key_q;
    assign busy          = busy_q;
    assign found         = found_q;
    assign exhausted     = exhausted_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: two instances (small range, single all-ones key)
// driven by a transaction-level script that predicts every output cycle.
module tb_rc4_key_search_ctrl;

    localparam int unsigned    KW   = 24;
    localparam logic [KW-1:0]  KS_A = 24'd5;
    localparam logic [KW-1:0]  KE_A = 24'd7;
    localparam logic [KW-1:0]  KS_B = 24'hFF_FFFF;
    localparam logic [KW-1:0]  KE_B = 24'hFF_FFFF;
    localparam int unsigned    TMO  = 16;

    // Strobe vector order: {init_start, shuffle_start, decrypt_start, phase_abort, check_restart}
    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_INIT = 5'b10000;
    localparam logic [4:0] S_SHUF = 5'b01000;
    localparam logic [4:0] S_DEC  = 5'b00100;
    localparam logic [4:0] S_ABT  = 5'b00011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic [1:0] start_v = '0, initf_v = '0, shuff_v = '0, decf_v = '0, kiw_v = '0;
    logic [1:0] init_s_v, shuf_s_v, dec_s_v, abort_v, crst_v;
    logic [1:0] busy_v, found_v, exh_v, tmo_v;
    logic [KW-1:0] key_a, key_b;

    rc4_key_search_ctrl #(
        .KEY_WIDTH(KW), .KEY_START(KS_A), .KEY_END(KE_A), .TIMEOUT_CYCLES(TMO)
    ) u_dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .init_finish(initf_v[0]), .shuffle_finish(shuff_v[0]),
        .decrypt_finish(decf_v[0]), .key_is_wrong(kiw_v[0]),
        .init_start(init_s_v[0]), .shuffle_start(shuf_s_v[0]),
        .decrypt_start(dec_s_v[0]), .phase_abort(abort_v[0]),
        .check_restart(crst_v[0]), .secret_key(key_a), .busy(busy_v[0]),
        .found(found_v[0]), .exhausted(exh_v[0]), .timeout_err(tmo_v[0])
    );

    rc4_key_search_ctrl #(
        .KEY_WIDTH(KW), .KEY_START(KS_B), .KEY_END(KE_B), .TIMEOUT_CYCLES(TMO)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .init_finish(initf_v[1]), .shuffle_finish(shuff_v[1]),
        .decrypt_finish(decf_v[1]), .key_is_wrong(kiw_v[1]),
        .init_start(init_s_v[1]), .shuffle_start(shuf_s_v[1]),
        .decrypt_start(dec_s_v[1]), .phase_abort(abort_v[1]),
        .check_restart(crst_v[1]), .secret_key(key_b), .busy(busy_v[1]),
        .found(found_v[1]), .exhausted(exh_v[1]), .timeout_err(tmo_v[1])
    );

    // Expected outputs for the cycle following the next rising edge.
    logic [4:0]    e_str  [2];
    logic [KW-1:0] e_key  [2];
    logic          e_busy [2];
    logic          e_found[2];
    logic          e_exh  [2];
    logic          e_tmo  [2];

    int n_chk     = 0;
    int n_fail    = 0;
    int n_init_a  = 0;
    int n_abort_a = 0;

    function automatic logic [KW-1:0] ks(input int d);
        return (d == 0) ? KS_A : KS_B;
    endfunction

    function automatic logic [KW-1:0] ke(input int d);
        return (d == 0) ? KE_A : KE_B;
    endfunction

    task automatic check_outputs();
        logic [4:0]    a_str;
        logic [3:0]    a_lvl, x_lvl;
        logic [KW-1:0] a_key;
        for (int d = 0; d < 2; d++) begin
            a_str = {init_s_v[d], shuf_s_v[d], dec_s_v[d], abort_v[d], crst_v[d]};
            a_lvl = {busy_v[d], found_v[d], exh_v[d], tmo_v[d]};
            x_lvl = {e_busy[d], e_found[d], e_exh[d], e_tmo[d]};
            a_key = (d == 0) ? key_a : key_b;
            n_chk++;
            if (a_str !== e_str[d] || a_lvl !== x_lvl || a_key !== e_key[d]) begin
                n_fail++;
                $display("FAIL cycle_outputs dut%0d t=%0t: got str=%b lvl(busy,found,exh,tmo)=%b key=%h, expected str=%b lvl=%b key=%h",
                         d, $time, a_str, a_lvl, a_key, e_str[d], x_lvl, e_key[d]);
            end
        end
        if (init_s_v[0] === 1'b1) n_init_a++;
        if (abort_v[0] === 1'b1)  n_abort_a++;
    endtask

    task automatic lit_check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: inputs already set, pulses dropped after the edge, outputs compared at negedge.
    task automatic step();
        @(posedge clk);
        #1;
        start_v = '0;
        initf_v = '0;
        shuff_v = '0;
        decf_v  = '0;
        @(negedge clk);
        check_outputs();
        e_str[0] = S_NONE;
        e_str[1] = S_NONE;
    endtask

    task automatic expect_reset();
        for (int d = 0; d < 2; d++) begin
            e_str[d]   = S_NONE;
            e_key[d]   = ks(d);
            e_busy[d]  = 1'b0;
            e_found[d] = 1'b0;
            e_exh[d]   = 1'b0;
            e_tmo[d]   = 1'b0;
        end
        kiw_v = '0;
    endtask

    task automatic launch(input int d);
        start_v[d] = 1'b1;
        e_str[d]   = S_INIT;
        e_key[d]   = ks(d);
        e_busy[d]  = 1'b1;
        e_found[d] = 1'b0;
        e_exh[d]   = 1'b0;
        e_tmo[d]   = 1'b0;
        step();
    endtask

    // Random pulses a waiting controller must ignore (other phases' finishes, start while busy).
    task automatic strays(input int d, input int which);
        if ($urandom_range(0, 3) == 0) begin
            if (which == 0) shuff_v[d] = 1'b1;
            else            initf_v[d] = 1'b1;
        end
        if ($urandom_range(0, 3) == 0) begin
            if (which == 2) shuff_v[d] = 1'b1;
            else            decf_v[d]  = 1'b1;
        end
        if ($urandom_range(0, 5) == 0) start_v[d] = 1'b1;
    endtask

    // Init (which=0) or shuffle (which=1): GO edge, extra wait cycles, then the finish edge.
    task automatic phase(input int d, input int which, input int extra, input int force_at,
                         input logic [4:0] next_str);
        for (int i = 0; i <= extra; i++) begin
            strays(d, which);
            if (i == force_at) begin
                if (which == 0) shuff_v[d] = 1'b1;
                else            initf_v[d] = 1'b1;
            end
            step();
        end
        if (which == 0) initf_v[d] = 1'b1;
        else            shuff_v[d] = 1'b1;
        e_str[d] = next_str;
        step();
    endtask

    task automatic dec_phase(input int d, input int extra, input bit wrong, input bit both,
                             output bit done);
        for (int i = 0; i <= extra; i++) begin
            strays(d, 2);
            step();
        end
        if (wrong) begin
            kiw_v[d] = 1'b1;
            if (both) decf_v[d] = 1'b1;
            e_str[d] = S_ABT;
            step();
            kiw_v[d] = 1'b0;
            step();
            if (e_key[d] == ke(d)) begin
                e_busy[d] = 1'b0;
                e_exh[d]  = 1'b1;
                done      = 1'b1;
            end else begin
                e_key[d] = e_key[d] + KW'(1);
                e_str[d] = S_INIT;
                done     = 1'b0;
            end
            step();
        end else begin
            decf_v[d]  = 1'b1;
            e_busy[d]  = 1'b0;
            e_found[d] = 1'b1;
            done       = 1'b1;
            step();
        end
    endtask

    task automatic search_random(input int d);
        bit done;
        done = 1'b0;
        launch(d);
        while (!done) begin
            phase(d, 0, $urandom_range(0, 5), -1, S_SHUF);
            phase(d, 1, $urandom_range(0, 5), -1, S_DEC);
            dec_phase(d, $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0), done);
        end
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) step();
    endtask

    initial begin
        bit done;
        int ab0;

        // Reset: everything idle, key at KEY_START.
        rst = 1'b1;
        expect_reset();
        step();
        step();
        rst = 1'b0;
        step();
        lit_check("reset_key_a", 32'(key_a), 32'd5);
        lit_check("reset_busy_a", 32'(busy_v[0]), 32'd0);

        // Keys 5 and 6 wrong (6 with simultaneous decrypt_finish), key 7 found.
        n_init_a = 0;
        launch(0);
        phase(0, 0, 2, 1, S_SHUF);
        phase(0, 1, 1, -1, S_DEC);
        dec_phase(0, 1, 1'b1, 1'b0, done);
        phase(0, 0, 0, -1, S_SHUF);
        phase(0, 1, 0, -1, S_DEC);
        dec_phase(0, 2, 1'b1, 1'b1, done);
        phase(0, 0, 1, -1, S_SHUF);
        phase(0, 1, 2, -1, S_DEC);
        dec_phase(0, 0, 1'b0, 1'b0, done);
        step();
        lit_check("found_level", 32'(found_v[0]), 32'd1);
        lit_check("found_key", 32'(key_a), 32'd7);
        lit_check("init_start_pulses", 32'(n_init_a), 32'd3);

        // Single all-ones key, wrong: exhausted with no wrap.
        launch(1);
        phase(1, 0, 0, -1, S_SHUF);
        phase(1, 1, 1, -1, S_DEC);
        dec_phase(1, 1, 1'b1, 1'b0, done);
        step();
        lit_check("exhausted_level", 32'(exh_v[1]), 32'd1);
        lit_check("exhausted_key_nowrap", 32'(key_b), 32'hFF_FFFF);
        lit_check("exhausted_not_found", 32'(found_v[1]), 32'd0);

        // Reset while waiting on shuffle_finish.
        launch(0);
        phase(0, 0, 1, -1, S_SHUF);
        step();
        step();
        rst = 1'b1;
        expect_reset();
        step();
        rst = 1'b0;
        lit_check("midreset_busy", 32'(busy_v[0]), 32'd0);
        lit_check("midreset_key", 32'(key_a), 32'd5);
        step();

        // Randomized searches on both instances.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 4) == 0) search_random(1);
            else                            search_random(0);
        end

`ifdef RC4_PHASE_WATCHDOG_EN
        // init_finish never arrives: 16 wait cycles, then TIMEOUT with one abort pulse.
        launch(0);
        ab0 = n_abort_a;
        for (int i = 0; i < 16; i++) step();
        e_str[0]  = S_ABT;
        e_busy[0] = 1'b0;
        e_tmo[0]  = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        lit_check("timeout_err_held", 32'(tmo_v[0]), 32'd1);
        lit_check("timeout_abort_pulses", 32'(n_abort_a - ab0), 32'd1);
        search_random(0);
`else
        ab0 = 0;
        lit_check("timeout_tied_low", 32'(tmo_v[0]) + 32'(ab0), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
